// File: rtl/rf_ld_indirect_reader_pkg.sv
// Shared types and default geometry for the LD-indirect register-file reader.
// The optional REQ timeout (macro LD_TIMEOUT_EN) uses TIMEOUT_DEF as its default limit.
package rf_ld_indirect_reader_pkg;

  localparam int unsigned DATA_W_DEF  = 4;
  localparam int unsigned NREG_DEF    = 4;
  localparam int unsigned RA_W_DEF    = 2;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPtr  = 2'd1,
    StReq  = 2'd2,
    StWb   = 2'd3
  } ld_state_e;

endpackage

// File: rtl/rf_ld_indirect_reader_if.sv
// Bundle of control, register-file, memory and write-back signals around the reader.
// The err line exists only when LD_TIMEOUT_EN is defined.
interface rf_ld_indirect_reader_if
  import rf_ld_indirect_reader_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned RA_W   = RA_W_DEF
) ();

  logic              start;
  logic [RA_W-1:0]   rs;
  logic [RA_W-1:0]   rd;
  logic [RA_W-1:0]   rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              mem_req;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [NREG-1:0]   wb_sel;
  logic [DATA_W-1:0] wb_data;
  logic              busy;
  logic              done;
`ifdef LD_TIMEOUT_EN
  logic              err;
`endif

  // The sequencer itself.
  modport slave (
    input  start, rs, rd, rf_rd_data, mem_ack, mem_rdata,
    output rf_rd_addr, mem_req, mem_addr, wb_sel, wb_data, busy, done
`ifdef LD_TIMEOUT_EN
    , output err
`endif
  );

  // Control unit, register file and memory side.
  modport master (
    output start, rs, rd, rf_rd_data, mem_ack, mem_rdata,
    input  rf_rd_addr, mem_req, mem_addr, wb_sel, wb_data, busy, done
`ifdef LD_TIMEOUT_EN
    , input err
`endif
  );

endinterface

// File: rtl/rf_ld_indirect_reader_sel_decode.sv
// Register-index to one-hot write-enable decoder (rf_sel_decode); all zeros when disabled.
module rf_sel_decode
  import rf_ld_indirect_reader_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] i_idx,
  input  logic            i_en,
  output logic [NREG-1:0] o_sel
);

  always_comb begin
    o_sel = '0;
    if (i_en) begin
      o_sel[i_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rf_ld_indirect_reader.sv
// Sequencer for LD Rd, [Rs]: read pointer Rs, fetch memory at it, write the word into Rd.
// Define LD_TIMEOUT_EN to bound the memory wait by TIMEOUT cycles and report err.
module rf_ld_indirect_reader
  import rf_ld_indirect_reader_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned NREG    = NREG_DEF,
  parameter int unsigned RA_W    = RA_W_DEF
`ifdef LD_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = TIMEOUT_DEF
`endif
) (
  input logic clk,
  input logic reset,
  rf_ld_indirect_reader_if.slave bus
);

  ld_state_e         r_state;
  logic [RA_W-1:0]   r_rs;
  logic [RA_W-1:0]   r_rd;
  logic              r_mem_req;
  logic [DATA_W-1:0] r_mem_addr;
  logic [NREG-1:0]   r_wb_sel;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_busy;
  logic              r_done;

  logic              w_wb_en;
  logic [NREG-1:0]   w_sel;

`ifdef LD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0]   r_cnt;
  logic              r_err;
`endif

  // Write enable is computed one cycle early so wb_sel is registered into WB.
  assign w_wb_en = (r_state == StReq) && bus.mem_ack;

  rf_sel_decode #(
    .NREG (NREG),
    .RA_W (RA_W)
  ) u_sel_decode (
    .i_idx (r_rd),
    .i_en  (w_wb_en),
    .o_sel (w_sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_rs       <= '0;
      r_rd       <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_wb_sel   <= '0;
      r_wb_data  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef LD_TIMEOUT_EN
      r_cnt      <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_done   <= 1'b0;
      r_wb_sel <= '0;
`ifdef LD_TIMEOUT_EN
      r_err    <= 1'b0;
`endif
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_rs    <= bus.rs;
            r_rd    <= bus.rd;
            r_busy  <= 1'b1;
            r_state <= StPtr;
          end
        end
        StPtr: begin
          // The address register doubles as the pointer register.
          r_mem_addr <= bus.rf_rd_data;
          r_mem_req  <= 1'b1;
`ifdef LD_TIMEOUT_EN
          r_cnt      <= '0;
`endif
          r_state    <= StReq;
        end
        StReq: begin
          if (bus.mem_ack) begin
            r_wb_data <= bus.mem_rdata;
            r_wb_sel  <= w_sel;
            r_done    <= 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= StWb;
`ifdef LD_TIMEOUT_EN
          end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= StIdle;
          end else begin
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end
        StWb: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.rf_rd_addr = r_rs;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.wb_sel     = r_wb_sel;
  assign bus.wb_data    = r_wb_data;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
`ifdef LD_TIMEOUT_EN
  assign bus.err        = r_err;
`endif

endmodule

// File: tb/tb_rf_ld_indirect_reader.sv
// Self-checking bench: register-file and memory models around the reader, expected
// write-backs queued at start and compared when done pulses.
module tb_rf_ld_indirect_reader;
  import rf_ld_indirect_reader_pkg::*;

  localparam int unsigned DW = DATA_W_DEF;
  localparam int unsigned NR = NREG_DEF;
  localparam int unsigned RW = RA_W_DEF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rf_ld_indirect_reader_if #(.DATA_W(DW), .NREG(NR), .RA_W(RW)) bus ();

  rf_ld_indirect_reader #(.DATA_W(DW), .NREG(NR), .RA_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] rf_m  [NR];
  logic [DW-1:0] mem_m [2**DW];
  logic          poke_en;
  logic [RW-1:0] poke_idx;
  logic [DW-1:0] poke_val;

  assign bus.rf_rd_data = rf_m[bus.rf_rd_addr];

  always @(posedge clk) begin
    if (poke_en) rf_m[poke_idx] <= poke_val;
    else for (int i = 0; i < NR; i++) if (bus.wb_sel[i]) rf_m[i] <= bus.wb_data;
  end

  typedef struct packed {
    logic [NR-1:0] sel;
    logic [DW-1:0] data;
    logic [DW-1:0] addr;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic set_rf(input logic [RW-1:0] idx, input logic [DW-1:0] val);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.rf_rd_addr, bus.mem_req, bus.mem_addr, bus.wb_sel, bus.wb_data, bus.busy,
         bus.done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h req=%b maddr=%h sel=%b wdata=%h busy=%b done=%b, want all 0",
               bus.rf_rd_addr, bus.mem_req, bus.mem_addr, bus.wb_sel, bus.wb_data, bus.busy, bus.done);
    end
`ifdef LD_TIMEOUT_EN
    n_tests++;
    if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  // One LD operation; wait_n extra REQ cycles before ack; spam keeps start high throughout.
  task automatic run_ld(input logic [RW-1:0] rs, input logic [RW-1:0] rd, input int wait_n,
                        input bit spam);
    exp_t e, got_e;
    int req_n = 0, sel_n = 0;
    bit got = 0;
    e.addr = rf_m[rs];
    e.data = mem_m[e.addr];
    e.sel  = NR'(1) << rd;
    sb.push_back(e);
    bus.start = 1'b1; bus.rs = rs; bus.rd = rd;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge clk);
      bus.start = spam; bus.rs = ~rs; bus.rd = ~rd;
      if (bus.wb_sel !== '0) sel_n++;
      n_tests++;
      if (bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL busy_active: cycle %0d got %b want 1", cyc, bus.busy);
      end
      if (cyc == 1) begin
        n_tests++;
        if (bus.rf_rd_addr !== rs) begin
          n_fail++; $display("FAIL rf_rd_addr: got %0d want %0d", bus.rf_rd_addr, rs);
        end
      end
      if (bus.mem_req === 1'b1) begin
        req_n++;
        n_tests++;
        if (bus.mem_addr !== e.addr) begin
          n_fail++; $display("FAIL mem_addr: cycle %0d got %h want %h", cyc, bus.mem_addr, e.addr);
        end
        bus.mem_ack   = (req_n > wait_n);
        bus.mem_rdata = bus.mem_ack ? mem_m[e.addr] : DW'($urandom);
      end else begin
        // Spurious ack during PTR must be ignored.
        bus.mem_ack   = (cyc == 1);
        bus.mem_rdata = DW'($urandom);
      end
      if (bus.done === 1'b1) begin
        got = 1;
        got_e = sb.pop_front();
        n_tests += 3;
        if (bus.wb_sel !== got_e.sel) begin
          n_fail++; $display("FAIL wb_sel: got %b want %b", bus.wb_sel, got_e.sel);
        end
        if (bus.wb_data !== got_e.data) begin
          n_fail++; $display("FAIL wb_data: got %h want %h", bus.wb_data, got_e.data);
        end
        if (cyc != 3 + wait_n) begin
          n_fail++; $display("FAIL done_latency: got %0d want %0d", cyc, 3 + wait_n);
        end
      end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: no done within 40 cycles");
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(negedge clk);
    bus.start = 1'b0; bus.mem_ack = 1'b0;
    n_tests += 3;
    if ({bus.busy, bus.done, bus.wb_sel} !== '0) begin
      n_fail++; $display("FAIL after_wb: got busy=%b done=%b sel=%b want 0", bus.busy, bus.done, bus.wb_sel);
    end
    if (rf_m[rd] !== e.data) begin
      n_fail++; $display("FAIL rf_write: rf[%0d] got %h want %h", rd, rf_m[rd], e.data);
    end
    if (sel_n != 1) begin
      n_fail++; $display("FAIL wb_pulses: got %0d want 1", sel_n);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] old = rf_m[0];
    int k = 0;
    bus.start = 1'b1; bus.rs = 2'd1; bus.rd = 2'd0;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.mem_req !== 1'b1 && k < 10) begin @(negedge clk); k++; end
    n_tests++;
    if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL reach_req: got %b want 1", bus.mem_req); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if ({bus.mem_req, bus.busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid: got req=%b busy=%b want 0", bus.mem_req, bus.busy);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 4'hF;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({bus.done, bus.wb_sel, bus.mem_req} !== '0) begin
        n_fail++; $display("FAIL late_ack: got done=%b sel=%b req=%b want 0", bus.done, bus.wb_sel, bus.mem_req);
      end
    end
    bus.mem_ack = 1'b0;
    n_tests++;
    if (rf_m[0] !== old) begin n_fail++; $display("FAIL no_write: rf[0] got %h want %h", rf_m[0], old); end
  endtask

`ifdef LD_TIMEOUT_EN
  task automatic test_timeout();
    int req_n = 0;
    bit seen = 0;
    bus.start = 1'b1; bus.rs = 2'd1; bus.rd = 2'd2;
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.mem_ack = 1'b0;
      if (bus.mem_req === 1'b1) req_n++;
      if (bus.err === 1'b1) begin
        seen = 1;
        n_tests += 3;
        if (req_n != int'(TIMEOUT_DEF) || cyc != int'(TIMEOUT_DEF) + 2) begin
          n_fail++; $display("FAIL timeout_len: got req=%0d cyc=%0d want %0d/%0d", req_n, cyc,
                             TIMEOUT_DEF, TIMEOUT_DEF + 2);
        end
        if ({bus.mem_req, bus.busy, bus.done} !== 3'b000) begin
          n_fail++; $display("FAIL timeout_state: got req=%b busy=%b done=%b want 0", bus.mem_req, bus.busy, bus.done);
        end
        if (bus.wb_sel !== '0) begin n_fail++; $display("FAIL timeout_sel: got %b want 0", bus.wb_sel); end
      end
    end
    if (!seen) begin n_tests++; n_fail++; $display("FAIL timeout_err: no err within 60 cycles"); end
    @(negedge clk);
    n_tests++;
    if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b want 0", bus.err); end
  endtask
`endif

  initial begin
    reset = 1'b1; poke_en = 1'b0; poke_idx = '0; poke_val = '0;
    bus.start = 1'b0; bus.rs = '0; bus.rd = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 2**DW; i++) mem_m[i] = DW'(i * 7 + 3);
    mem_m[4'hA] = 4'h7;
    mem_m[4'h5] = 4'hC;
    @(negedge clk);
    test_reset();
    set_rf(2'd0, 4'h3);
    set_rf(2'd1, 4'hA);
    set_rf(2'd2, 4'h6);
    set_rf(2'd3, 4'h5);
    run_ld(2'd1, 2'd2, 0, 1'b0);  // basic: addr A, data 7, sel 0100
    run_ld(2'd1, 2'd2, 3, 1'b0);  // three wait cycles
    run_ld(2'd3, 2'd3, 0, 1'b0);  // rs == rd: addr 5, data C
    run_ld(2'd1, 2'd0, 2, 1'b1);  // start held high while busy
    run_ld(2'd0, 2'd1, 0, 1'b0);  // back to back
    run_ld(2'd1, 2'd2, 1, 1'b0);
    test_reset_mid();
    run_ld(2'd2, 2'd3, 1, 1'b0);
`ifdef LD_TIMEOUT_EN
    test_timeout();
    run_ld(2'd3, 2'd0, 0, 1'b0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
